// File: rtl/config_loader_pkg.sv
// Shared definitions for config_loader: FSM state encoding, error codes and row address helper.
// CHECK is only reachable when CFG_LOADER_CHECKSUM_EN is defined.
package config_loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_WB_WRITE,
      ST_NEXT_NODE,
      ST_CHECK,
      ST_DONE,
      ST_ERROR
   } state_e;

   localparam logic [1:0] ERR_NONE = 2'd0;
   localparam logic [1:0] ERR_BUS  = 2'd1;
   localparam logic [1:0] ERR_CSUM = 2'd2;

   // Wraps at 32 bits; soclet and row are at most 15.
   function automatic logic [31:0] row_addr(input logic [31:0] base,
                                            input logic [3:0]  soclet,
                                            input logic [3:0]  row,
                                            input int unsigned stride_log2);
      return base + ({28'd0, soclet} << stride_log2) + ({28'd0, row} << 2);
   endfunction

endpackage

// File: rtl/config_loader_wb_write_retry.sv
// Wishbone write engine: owns cyc/stb, the per-attempt timeout counter and the retry counter,
// and reports a single-cycle wr_ok_o / wr_fail_o to the loader FSM.
module wb_write_retry #(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int MAX_RETRIES    = 3
) (
   input  logic clk,
   input  logic rst_i,
   input  logic launch_i,
   input  logic ack_i,
   input  logic err_i,
   output logic cyc_o,
   output logic wr_ok_o,
   output logic wr_fail_o
);
   import config_loader_pkg::*;

   localparam logic [7:0] TMO_LAST  = 8'(TIMEOUT_CYCLES - 1);
   localparam logic [2:0] RETRY_MAX = 3'(MAX_RETRIES);

   logic       cyc_q, cyc_d, gap_q, gap_d, ok_q, ok_d, fail_q, fail_d;
   logic [7:0] tmo_q, tmo_d;
   logic [2:0] retry_q, retry_d;
   logic       attempt_bad;

   always_comb begin
      cyc_d       = cyc_q;
      gap_d       = 1'b0;
      ok_d        = 1'b0;
      fail_d      = 1'b0;
      tmo_d       = tmo_q;
      retry_d     = retry_q;
      // err beats ack; ack beats the expiry cycle
      attempt_bad = cyc_q && (err_i || (!ack_i && tmo_q == TMO_LAST));
      if (launch_i) begin
         cyc_d   = 1'b1;
         tmo_d   = '0;
         retry_d = '0;
      end else if (gap_q) begin
         cyc_d = 1'b1;
         tmo_d = '0;
      end else if (cyc_q) begin
         if (attempt_bad) begin
            cyc_d = 1'b0;
            tmo_d = '0;
            if (retry_q == RETRY_MAX) begin
               fail_d  = 1'b1;
               retry_d = '0;
            end else begin
               gap_d   = 1'b1;
               retry_d = retry_q + 3'd1;
            end
         end else if (ack_i) begin
            cyc_d   = 1'b0;
            ok_d    = 1'b1;
            retry_d = '0;
         end else begin
            tmo_d = tmo_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst_i) begin
         cyc_q   <= 1'b0;
         gap_q   <= 1'b0;
         ok_q    <= 1'b0;
         fail_q  <= 1'b0;
         tmo_q   <= '0;
         retry_q <= '0;
      end else begin
         cyc_q   <= cyc_d;
         gap_q   <= gap_d;
         ok_q    <= ok_d;
         fail_q  <= fail_d;
         tmo_q   <= tmo_d;
         retry_q <= retry_d;
      end
   end

   assign cyc_o     = cyc_q;
   assign wr_ok_o   = ok_q;
   assign wr_fail_o = fail_q;

endmodule

// File: rtl/config_loader.sv
// Streams flash configuration words into SoClet row registers over Wishbone.
// Define CFG_LOADER_CHECKSUM_EN to require a trailing XOR checksum word after the last row.
module config_loader #(
   parameter int          NUM_SOCLETS     = 9,
   parameter int          ROWS_PER_SOCLET = 10,
   parameter logic [31:0] BASE_ADDR       = 32'h1000,
   parameter int          STRIDE_LOG2     = 6,
   parameter int          TIMEOUT_CYCLES  = 255,
   parameter int          MAX_RETRIES     = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        bypass_en,
   input  logic        start,
   input  logic        word_ready,
   input  logic [31:0] shifted_word,
   output logic        fetch_en,
   output logic        flash_csb,
   output logic [31:0] wbs_adr,
   output logic [31:0] wbs_dat,
   output logic        wbs_cyc,
   output logic        wbs_stb,
   output logic        wbs_we,
   output logic [3:0]  wbs_sel,
   input  logic        wbs_ack,
   input  logic        wbs_err,
   output logic        done_loading,
   output logic        load_error,
   output logic [1:0]  err_code
);
   import config_loader_pkg::*;

   localparam logic [3:0] LAST_ROW    = 4'(ROWS_PER_SOCLET - 1);
   localparam logic [3:0] LAST_SOCLET = 4'(NUM_SOCLETS - 1);

   logic        rst;
   state_e      state_q, state_d;
   logic [3:0]  soclet_q, soclet_d, row_q, row_d;
   logic [31:0] adr_q, adr_d, dat_q, dat_d;
   logic        csb_q, csb_d, done_q, done_d, lerr_q, lerr_d;
   logic [1:0]  ecode_q, ecode_d;
   logic        launch, wr_ok, wr_fail, cyc;
`ifdef CFG_LOADER_CHECKSUM_EN
   logic [31:0] csum_q, csum_d;
`endif

   assign rst = reset | bypass_en;

   always_comb begin
      state_d  = state_q;
      soclet_d = soclet_q;
      row_d    = row_q;
      adr_d    = adr_q;
      dat_d    = dat_q;
      csb_d    = csb_q;
      done_d   = done_q;
      lerr_d   = lerr_q;
      ecode_d  = ecode_q;
      launch   = 1'b0;
      fetch_en = 1'b0;
`ifdef CFG_LOADER_CHECKSUM_EN
      csum_d   = csum_q;
`endif
      case (state_q)
         ST_IDLE, ST_DONE, ST_ERROR: begin
            if (start) begin
               state_d  = ST_FETCH;
               csb_d    = 1'b0;
               soclet_d = '0;
               row_d    = '0;
               done_d   = 1'b0;
               lerr_d   = 1'b0;
               ecode_d  = ERR_NONE;
`ifdef CFG_LOADER_CHECKSUM_EN
               csum_d   = '0;
`endif
            end
         end
         ST_FETCH: begin
            fetch_en = 1'b1;
            if (word_ready) begin
               launch  = 1'b1;
               dat_d   = shifted_word;
               adr_d   = row_addr(BASE_ADDR, soclet_q, row_q, STRIDE_LOG2);
               state_d = ST_WB_WRITE;
`ifdef CFG_LOADER_CHECKSUM_EN
               csum_d  = csum_q ^ shifted_word;
`endif
            end
         end
         ST_WB_WRITE: begin
            if (wr_fail) begin
               state_d = ST_ERROR;
               csb_d   = 1'b1;
               lerr_d  = 1'b1;
               ecode_d = ERR_BUS;
            end else if (wr_ok) begin
               state_d = ST_NEXT_NODE;
            end
         end
         ST_NEXT_NODE: begin
            if (row_q != LAST_ROW) begin
               row_d   = row_q + 4'd1;
               state_d = ST_FETCH;
            end else if (soclet_q != LAST_SOCLET) begin
               row_d    = '0;
               soclet_d = soclet_q + 4'd1;
               state_d  = ST_FETCH;
            end else begin
`ifdef CFG_LOADER_CHECKSUM_EN
               state_d = ST_CHECK;
`else
               state_d = ST_DONE;
               csb_d   = 1'b1;
               done_d  = 1'b1;
`endif
            end
         end
`ifdef CFG_LOADER_CHECKSUM_EN
         ST_CHECK: begin
            fetch_en = 1'b1;
            if (word_ready) begin
               csb_d = 1'b1;
               if (shifted_word == csum_q) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = ST_ERROR;
                  lerr_d  = 1'b1;
                  ecode_d = ERR_CSUM;
               end
            end
         end
`endif
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         soclet_q <= '0;
         row_q    <= '0;
         adr_q    <= '0;
         dat_q    <= '0;
         csb_q    <= 1'b1;
         done_q   <= 1'b0;
         lerr_q   <= 1'b0;
         ecode_q  <= ERR_NONE;
`ifdef CFG_LOADER_CHECKSUM_EN
         csum_q   <= '0;
`endif
      end else begin
         state_q  <= state_d;
         soclet_q <= soclet_d;
         row_q    <= row_d;
         adr_q    <= adr_d;
         dat_q    <= dat_d;
         csb_q    <= csb_d;
         done_q   <= done_d;
         lerr_q   <= lerr_d;
         ecode_q  <= ecode_d;
`ifdef CFG_LOADER_CHECKSUM_EN
         csum_q   <= csum_d;
`endif
      end
   end

   wb_write_retry #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .MAX_RETRIES    (MAX_RETRIES)
   ) u_wb_write_retry (
      .clk       (clk),
      .rst_i     (rst),
      .launch_i  (launch),
      .ack_i     (wbs_ack),
      .err_i     (wbs_err),
      .cyc_o     (cyc),
      .wr_ok_o   (wr_ok),
      .wr_fail_o (wr_fail)
   );

   assign wbs_cyc      = cyc;
   assign wbs_stb      = cyc;
   assign wbs_we       = cyc;
   assign wbs_sel      = 4'hF;
   assign wbs_adr      = adr_q;
   assign wbs_dat      = dat_q;
   assign flash_csb    = csb_q;
   assign done_loading = done_q;
   assign load_error   = lerr_q;
   assign err_code     = ecode_q;

endmodule

// File: tb/tb_config_loader.sv
// Randomized bench for config_loader: random flash pacing and slave latency, injected
// err / ack+err / no-ack responses, bypass abort, checked against an address/word model.
module tb_config_loader;
   localparam int NSOC  = 9;
   localparam int NROW  = 10;
   localparam int TMO   = 8;
   localparam int MAXR  = 2;
   localparam int TOTAL = NSOC * NROW;
`ifdef CFG_LOADER_CHECKSUM_EN
   localparam bit CSUM_BUILD = 1'b1;
`else
   localparam bit CSUM_BUILD = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset, bypass_en, start, word_ready;
   logic [31:0] shifted_word;
   logic        fetch_en, flash_csb;
   logic [31:0] wbs_adr, wbs_dat;
   logic        wbs_cyc, wbs_stb, wbs_we;
   logic [3:0]  wbs_sel;
   logic        wbs_ack, wbs_err;
   logic        done_loading, load_error;
   logic [1:0]  err_code;

   config_loader #(
      .NUM_SOCLETS(NSOC), .ROWS_PER_SOCLET(NROW), .BASE_ADDR(32'h1000),
      .STRIDE_LOG2(6), .TIMEOUT_CYCLES(TMO), .MAX_RETRIES(MAXR)
   ) dut (
      .clk(clk), .reset(reset), .bypass_en(bypass_en), .start(start),
      .word_ready(word_ready), .shifted_word(shifted_word),
      .fetch_en(fetch_en), .flash_csb(flash_csb),
      .wbs_adr(wbs_adr), .wbs_dat(wbs_dat), .wbs_cyc(wbs_cyc), .wbs_stb(wbs_stb),
      .wbs_we(wbs_we), .wbs_sel(wbs_sel), .wbs_ack(wbs_ack), .wbs_err(wbs_err),
      .done_loading(done_loading), .load_error(load_error), .err_code(err_code)
   );

   initial forever #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Model: word w lands at base + soclet*64 + row*4
   function automatic logic [31:0] ref_addr(input int w);
      return 32'h1000 + 32'((w / NROW) * 64 + (w % NROW) * 4);
   endfunction

   // Scenario knobs and logs
   bit          slave_noack = 1'b0;
   int          err_att     = -1;
   int          both_att    = -1;
   int          lat_max     = 0;
   bit          trailer_good = 1'b1;
   logic [31:0] words[$];
   logic [31:0] att_adr[$];
   logic [31:0] att_dat[$];
   bit          att_fail[$];
   int          att_len[$];
   int          fed_n = 0;

   // Flash shift register
   initial begin
      logic [31:0] x;
      word_ready   = 1'b0;
      shifted_word = '0;
      forever begin
         @(negedge clk);
         word_ready = 1'b0;
         if (fetch_en && $urandom_range(0, 2) != 0) begin
            word_ready = 1'b1;
            if (fed_n < TOTAL) begin
               shifted_word = $urandom;
               words.push_back(shifted_word);
            end else begin
               x = '0;
               foreach (words[i]) x ^= words[i];
               shifted_word = trailer_good ? x : (x ^ 32'h1);
            end
            fed_n++;
         end
      end
   end

   // Wishbone slave and attempt logger
   initial begin
      int lat, wait_n, cur, len, since_ack;
      bit prev_cyc, exp_resume;
      wbs_ack = 1'b0; wbs_err = 1'b0;
      prev_cyc = 1'b0; cur = -1; lat = 0; wait_n = 0; len = 0;
      since_ack = -1; exp_resume = 1'b0;
      forever begin
         @(negedge clk);
         wbs_ack = 1'b0;
         wbs_err = 1'b0;
         if (since_ack >= 0) begin
            since_ack++;
            if (since_ack < 3) check("fetch_gap_after_ack", fetch_en, 0);
            else begin
               check("fetch_resume_after_ack", fetch_en, exp_resume);
               since_ack = -1;
            end
         end
         if (wbs_cyc && wbs_stb) begin
            if (!prev_cyc) begin
               att_adr.push_back(wbs_adr);
               att_dat.push_back(wbs_dat);
               cur = att_adr.size() - 1;
               check("fetch_off_in_write", fetch_en, 0);
               check("we_sel", {wbs_we, wbs_sel}, 5'h1F);
               lat = $urandom_range(0, lat_max);
               wait_n = 0;
               len = 0;
            end
            len++;
            if (!slave_noack && wait_n == lat) begin
               if (cur == both_att) begin
                  wbs_ack = 1'b1; wbs_err = 1'b1; att_fail.push_back(1'b1);
               end else if (cur == err_att) begin
                  wbs_err = 1'b1; att_fail.push_back(1'b1);
               end else begin
                  wbs_ack = 1'b1; att_fail.push_back(1'b0);
                  since_ack = 0;
                  exp_resume = (words.size() < TOTAL) || CSUM_BUILD;
               end
            end
            wait_n++;
         end else if (prev_cyc) begin
            att_len.push_back(len);
         end
         prev_cyc = wbs_cyc;
      end
   end

   task automatic clear_logs();
      words.delete(); att_adr.delete(); att_dat.delete();
      att_fail.delete(); att_len.delete();
      fed_n = 0;
   endtask

   task automatic do_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("start_csb_low", flash_csb, 0);
      check("start_fetch_en", fetch_en, 1);
      check("start_clears_flags", {done_loading, load_error, err_code}, 0);
   endtask

   task automatic wait_end();
      bit ended = 1'b0;
      for (int c = 0; c < 20000 && !ended; c++) begin
         @(negedge clk);
         if (done_loading || load_error) ended = 1'b1;
      end
      check("load_end_reached", ended, 1);
      repeat (2) @(negedge clk);
   endtask

   // Walk the attempt log: a failed attempt must be reissued for the same word
   task automatic check_attempts(input int exp_words);
      int w = 0;
      for (int k = 0; k < att_adr.size(); k++) begin
         check("attempt_in_range", w < words.size(), 1);
         if (w >= words.size()) break;
         check("adr", att_adr[k], ref_addr(w));
         check("dat", att_dat[k], words[w]);
         if (k < att_fail.size() && !att_fail[k]) w++;
      end
      check("words_written", w, exp_words);
   endtask

   task automatic check_done_ok();
      check("done_loading", done_loading, 1);
      check("load_error_clear", load_error, 0);
      check("err_code_none", err_code, 0);
      check("csb_high_at_done", flash_csb, 1);
      check("cyc_idle_at_done", wbs_cyc, 0);
      check_attempts(TOTAL);
   endtask

   initial begin
      reset = 1'b1; bypass_en = 1'b0; start = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_fetch_en", fetch_en, 0);
      check("rst_csb", flash_csb, 1);
      check("rst_cyc", wbs_cyc, 0);
      check("rst_stb", wbs_stb, 0);
      check("rst_we", wbs_we, 0);
      check("rst_adr", wbs_adr, 0);
      check("rst_dat", wbs_dat, 0);
      check("rst_flags", {done_loading, load_error, err_code}, 0);
      reset = 1'b0;

      // Ack after one cycle, clean load
      clear_logs();
      do_start();
      wait_end();
      check_done_ok();
      check("attempt_count", att_adr.size(), TOTAL);
      if (att_adr.size() == TOTAL) begin
         check("first_adr", att_adr[0], 32'h1000);
         check("soclet0_row9_adr", att_adr[9], 32'h1024);
         check("last_adr", att_adr[TOTAL-1], 32'h1224);
      end

      // err on word 5 first attempt, ack+err on a later attempt, random latency
      clear_logs();
      lat_max = 3; err_att = 5; both_att = 20;
      do_start();
      wait_end();
      check_done_ok();
      check("attempt_count_retries", att_adr.size(), TOTAL + 2);
      if (att_adr.size() > 6) check("reissue_word5_adr", att_adr[6], 32'h1014);
      err_att = -1; both_att = -1;

      // No ack at all: 3 attempts of TMO cycles each, then ERROR
      clear_logs();
      slave_noack = 1'b1;
      do_start();
      wait_end();
      check("tmo_load_error", load_error, 1);
      check("tmo_done_clear", done_loading, 0);
      check("tmo_err_code", err_code, 1);
      check("tmo_cyc_idle", wbs_cyc, 0);
      check("tmo_csb_high", flash_csb, 1);
      check("tmo_attempts", att_adr.size(), MAXR + 1);
      check("tmo_len_entries", att_len.size(), MAXR + 1);
      foreach (att_len[i]) check("tmo_attempt_len", att_len[i], TMO);
      foreach (att_adr[i]) check("tmo_attempt_adr", att_adr[i], 32'h1000);

      // Restart from ERROR with a normal slave
      clear_logs();
      slave_noack = 1'b0;
      do_start();
      wait_end();
      check_done_ok();

      // Bypass pulse in the middle of a write
      clear_logs();
      slave_noack = 1'b1;
      do_start();
      begin
         bit seen = 1'b0;
         for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge clk);
            if (wbs_cyc) seen = 1'b1;
         end
         check("bypass_cyc_seen", seen, 1);
      end
      @(negedge clk);
      bypass_en = 1'b1;
      @(negedge clk);
      bypass_en = 1'b0;
      check("bypass_cyc", wbs_cyc, 0);
      check("bypass_csb", flash_csb, 1);
      check("bypass_fetch_en", fetch_en, 0);
      check("bypass_adr", wbs_adr, 0);
      check("bypass_flags", {done_loading, load_error, err_code}, 0);
      repeat (3) @(negedge clk);
      clear_logs();
      slave_noack = 1'b0;
      lat_max = 2;
      do_start();
      wait_end();
      check_done_ok();
      if (att_adr.size() > 0) check("reload_first_adr", att_adr[0], 32'h1000);

`ifdef CFG_LOADER_CHECKSUM_EN
      // Wrong trailer
      clear_logs();
      trailer_good = 1'b0;
      do_start();
      wait_end();
      check("csum_load_error", load_error, 1);
      check("csum_err_code", err_code, 2);
      check("csum_done_clear", done_loading, 0);
      check("csum_csb_high", flash_csb, 1);
      check_attempts(TOTAL);
      trailer_good = 1'b1;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
